// File: rtl/wb_bridge_pkg.sv
// Shared definitions for the Wishbone bridge responder: defaults, state encoding.
package wb_bridge_pkg;

    localparam int unsigned DEF_AW      = 32;
    localparam int unsigned DEF_DW      = 32;
    localparam int unsigned DEF_TIMEOUT = 255;
    localparam int unsigned TMO_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/wb_bridge_responder_if.sv
// Request/response handshake fields plus the Wishbone classic master bus.
interface wb_bridge_responder_if
    import wb_bridge_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW
) ();

    logic            stb_sync_i;
    logic            ack_o;
    logic [AW-1:0]   xadr_i;
    logic [DW-1:0]   xdat_i;
    logic [DW/8-1:0] xsel_i;
    logic            xwe_i;
    logic [DW-1:0]   xdat_o;
    logic            xerr_o;

    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic            wb_we_o;
    logic [AW-1:0]   wb_adr_o;
    logic [DW/8-1:0] wb_sel_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW-1:0]   wb_dat_i;
    logic            wb_ack_i;
    logic            wb_err_i;

    // Bridge side: consumes the request, drives the response and the bus.
    modport slave (
        input  stb_sync_i, xadr_i, xdat_i, xsel_i, xwe_i,
        input  wb_dat_i, wb_ack_i, wb_err_i,
        output ack_o, xdat_o, xerr_o,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o
    );

    modport master (
        output stb_sync_i, xadr_i, xdat_i, xsel_i, xwe_i,
        output wb_dat_i, wb_ack_i, wb_err_i,
        input  ack_o, xdat_o, xerr_o,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o
    );

endinterface

// File: rtl/wb_bridge_timeout.sv
// Bus-cycle watchdog: counts enabled cycles and flags when TIMEOUT is reached.
module wb_bridge_timeout
    import wb_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk_s,
    input  logic reset_s_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TMO_W-1:0] count;

    always_ff @(posedge clk_s or negedge reset_s_n) begin
        if (!reset_s_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + TMO_W'(1);
        end
    end

    assign expired = (count == TMO_W'(TIMEOUT));

endmodule

// File: rtl/wb_bridge_responder.sv
// Four-phase request handshake in clk_s turned into one Wishbone classic cycle.
module wb_bridge_responder
    import wb_bridge_pkg::*;
#(
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  clk_s,
    input  logic                  reset_s_n,
    wb_bridge_responder_if.slave  bus
);

    state_e          state, state_nxt;
    logic            ack_q, ack_nxt;
    logic [DW-1:0]   xdat_q, xdat_nxt;
    logic            xerr_q, xerr_nxt;
    logic            cyc_q, cyc_nxt;
    logic            we_q, we_nxt;
    logic [AW-1:0]   adr_q, adr_nxt;
    logic [DW/8-1:0] sel_q, sel_nxt;
    logic [DW-1:0]   dat_q, dat_nxt;

    logic tmo_clr, tmo_en, tmo_expired, term;

    // Slave ack wins over err, and either wins over the watchdog.
    assign term    = bus.wb_ack_i || bus.wb_err_i || tmo_expired;
    assign tmo_clr = (state == ST_IDLE) && bus.stb_sync_i;
    assign tmo_en  = (state == ST_BUS) && !term;

    wb_bridge_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk_s     (clk_s),
        .reset_s_n (reset_s_n),
        .clr       (tmo_clr),
        .en        (tmo_en),
        .expired   (tmo_expired)
    );

    always_comb begin
        state_nxt = state;
        ack_nxt   = ack_q;
        xdat_nxt  = xdat_q;
        xerr_nxt  = xerr_q;
        cyc_nxt   = cyc_q;
        we_nxt    = we_q;
        adr_nxt   = adr_q;
        sel_nxt   = sel_q;
        dat_nxt   = dat_q;
        case (state)
            ST_IDLE: begin
                if (bus.stb_sync_i) begin
                    state_nxt = ST_BUS;
                    cyc_nxt   = 1'b1;
                    we_nxt    = bus.xwe_i;
                    adr_nxt   = bus.xadr_i;
                    sel_nxt   = bus.xsel_i;
                    dat_nxt   = bus.xdat_i;
                end
            end
            ST_BUS: begin
                if (term) begin
                    state_nxt = ST_DONE;
                    cyc_nxt   = 1'b0;
                    ack_nxt   = 1'b1;
                    if (bus.wb_ack_i) begin
                        xerr_nxt = 1'b0;
                        if (!we_q) xdat_nxt = bus.wb_dat_i;
                    end else begin
                        xerr_nxt = 1'b1;
                        xdat_nxt = '0;
                    end
                end
            end
            ST_DONE: begin
                if (!bus.stb_sync_i) begin
                    state_nxt = ST_IDLE;
                    ack_nxt   = 1'b0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_s or negedge reset_s_n) begin
        if (!reset_s_n) begin
            state  <= ST_IDLE;
            ack_q  <= 1'b0;
            xdat_q <= '0;
            xerr_q <= 1'b0;
            cyc_q  <= 1'b0;
            we_q   <= 1'b0;
            adr_q  <= '0;
            sel_q  <= '0;
            dat_q  <= '0;
        end else begin
            state  <= state_nxt;
            ack_q  <= ack_nxt;
            xdat_q <= xdat_nxt;
            xerr_q <= xerr_nxt;
            cyc_q  <= cyc_nxt;
            we_q   <= we_nxt;
            adr_q  <= adr_nxt;
            sel_q  <= sel_nxt;
            dat_q  <= dat_nxt;
        end
    end

    assign bus.ack_o    = ack_q;
    assign bus.xdat_o   = xdat_q;
    assign bus.xerr_o   = xerr_q;
    assign bus.wb_cyc_o = cyc_q;
    assign bus.wb_stb_o = cyc_q;
    assign bus.wb_we_o  = we_q;
    assign bus.wb_adr_o = adr_q;
    assign bus.wb_sel_o = sel_q;
    assign bus.wb_dat_o = dat_q;

endmodule
